// File: rtl/mux_line_scheduler_pkg.sv
// Shared definitions for the mux line scheduler and the UART command decoder.
// Holds the FSM state encodings and the index-width helper.
package mux_line_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_DWELL   = 2'd2,
        ST_ADVANCE = 2'd3
    } state_t;

    // Width of an index into n mux lines (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_line_scheduler_if.sv
// Command/status bundle between the UART command layer (master) and the
// mux line scheduler (slave).
//   cfg_valid/cfg_ready/cfg_mask/cfg_dwell : configuration write handshake
//   start/stop                             : scan control
//   strobe                                 : external advance strobe pin
//   mux_out/active_index                   : one-hot mux select and its index
//   integrate_en/frame_done/cfg_error      : correlator window and status
interface mux_line_scheduler_if
    import mux_line_scheduler_pkg::*;
#(
    parameter int MUX_LINES   = 16,
    parameter int DWELL_WIDTH = 24
);
    localparam int IW = idx_width(MUX_LINES);

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [MUX_LINES-1:0]   cfg_mask;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                   start;
    logic                   stop;
    logic                   strobe;
    logic [MUX_LINES-1:0]   mux_out;
    logic [IW-1:0]          active_index;
    logic                   integrate_en;
    logic                   frame_done;
    logic                   cfg_error;

    modport master (
        output cfg_valid, cfg_mask, cfg_dwell, start, stop, strobe,
        input  cfg_ready, mux_out, active_index, integrate_en, frame_done, cfg_error
    );

    modport slave (
        input  cfg_valid, cfg_mask, cfg_dwell, start, stop, strobe,
        output cfg_ready, mux_out, active_index, integrate_en, frame_done, cfg_error
    );

endinterface

// File: rtl/mux_line_scheduler_next_index.sv
// mux_next_index: combinational wrap-around search for the next enabled channel.
//   mask       : enabled channels
//   cur_index  : search starts at the bit above this index
//   next_index : first set mask bit above cur_index, wrapping to the lowest
//   wrap       : search wrapped (includes finding cur_index itself)
module mux_next_index
    import mux_line_scheduler_pkg::*;
#(
    parameter int MUX_LINES = 16
) (
    input  logic [MUX_LINES-1:0]            mask,
    input  logic [idx_width(MUX_LINES)-1:0] cur_index,
    output logic [idx_width(MUX_LINES)-1:0] next_index,
    output logic                            wrap
);
    localparam int IW = idx_width(MUX_LINES);
    localparam logic [IW:0] LINES = (IW+1)'(MUX_LINES);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        next_index = cur_index;
        wrap       = 1'b0;
        found      = 1'b0;
        cand       = '0;
        for (int off = 1; off <= MUX_LINES; off++) begin
            cand = {1'b0, cur_index} + (IW+1)'(off);
            if (cand >= LINES) begin
                cand = cand - LINES;
            end
            if (!found && mask[cand[IW-1:0]]) begin
                found      = 1'b1;
                next_index = cand[IW-1:0];
                wrap       = (cand[IW-1:0] <= cur_index);
            end
        end
    end

endmodule

// File: rtl/mux_line_scheduler.sv
// mux_line_scheduler: steps a one-hot mux through the enabled channels,
// settling after each change and then opening an integration window.
//   sysclk, reset : clock and synchronous active-high reset
//   bus (slave)   : config handshake, start/stop, strobe, mux select and status
// Optional feature macro: MUX_STROBE_SYNC_EN - ADVANCE waits for a synchronized
// rising edge on bus.strobe instead of lasting a single cycle.
//
// state   | meaning
// IDLE    | mux off, config writes accepted, waiting for start
// SETTLE  | new mux select applied, waiting SETTLE_CYCLES for it to settle
// DWELL   | integrate_en high for max(dwell,1) cycles
// ADVANCE | pick next enabled channel; frame_done when the pass wraps
module mux_line_scheduler
    import mux_line_scheduler_pkg::*;
#(
    parameter int MUX_LINES     = 16,
    parameter int DWELL_WIDTH   = 24,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                sysclk,
    input  logic                reset,
    mux_line_scheduler_if.slave bus
);
    localparam int IW = idx_width(MUX_LINES);
    localparam logic [DWELL_WIDTH-1:0] SETTLE_LOAD = DWELL_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [DWELL_WIDTH-1:0] ONE         = DWELL_WIDTH'(1);
    localparam logic [MUX_LINES-1:0]   BIT0        = MUX_LINES'(1);

    state_t                 state, state_nxt;
    logic [DWELL_WIDTH-1:0] cnt, cnt_nxt;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_nxt;
    logic [MUX_LINES-1:0]   mask_q, mask_nxt;
    logic [MUX_LINES-1:0]   mux_q, mux_nxt;
    logic [IW-1:0]          idx_q, idx_nxt;
    logic                   err_q, err_nxt;
    logic [IW-1:0]          search_from, search_index;
    logic                   search_wrap;
    logic                   advance_go;
    logic                   frame_pulse;

    // From IDLE, searching above the top line lands on the lowest set bit.
    assign search_from = (state == ST_IDLE) ? IW'(MUX_LINES - 1) : idx_q;

    mux_next_index #(.MUX_LINES(MUX_LINES)) u_next_index (
        .mask       (mask_q),
        .cur_index  (search_from),
        .next_index (search_index),
        .wrap       (search_wrap)
    );

`ifdef MUX_STROBE_SYNC_EN
    // Two synchronizer flops plus one history flop for rising-edge detect.
    logic [2:0] strobe_sync;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            strobe_sync <= '0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], bus.strobe};
        end
    end

    assign advance_go = strobe_sync[1] & ~strobe_sync[2];
`else
    logic unused_strobe;
    assign unused_strobe = bus.strobe;
    assign advance_go    = 1'b1;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            mux_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dwell_q <= dwell_nxt;
            mask_q  <= mask_nxt;
            mux_q   <= mux_nxt;
            idx_q   <= idx_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dwell_nxt   = dwell_q;
        mask_nxt    = mask_q;
        mux_nxt     = mux_q;
        idx_nxt     = idx_q;
        err_nxt     = err_q;
        frame_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    mask_nxt  = bus.cfg_mask;
                    dwell_nxt = bus.cfg_dwell;
                    err_nxt   = 1'b0;
                end
                // Start uses the mask already latched, not a same-cycle write.
                if (bus.start && !bus.stop) begin
                    if (mask_q == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = SETTLE_LOAD;
                        mux_nxt   = BIT0 << search_index;
                        idx_nxt   = search_index;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ST_DWELL;
                    cnt_nxt   = (dwell_q == '0) ? '0 : dwell_q - ONE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            ST_DWELL: begin
                if (cnt == '0) begin
                    state_nxt = ST_ADVANCE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            ST_ADVANCE: begin
                if (advance_go) begin
                    state_nxt   = ST_SETTLE;
                    cnt_nxt     = SETTLE_LOAD;
                    mux_nxt     = BIT0 << search_index;
                    idx_nxt     = search_index;
                    frame_pulse = search_wrap;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.stop) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            mux_nxt     = '0;
            idx_nxt     = '0;
            frame_pulse = 1'b0;
        end
    end

    assign bus.cfg_ready    = (state == ST_IDLE);
    assign bus.mux_out      = mux_q;
    assign bus.active_index = idx_q;
    assign bus.integrate_en = (state == ST_DWELL);
    assign bus.frame_done   = frame_pulse;
    assign bus.cfg_error    = err_q;

endmodule
